// File: rtl/strobe_check_if.sv
// Bus between a strobe_check monitor and whoever drives and reads it.
// master drives the observed strobes and controls and reads the status.
// slave is the monitor side.
interface strobe_check_if #(
    parameter int ERR_W = 16
) ();
    logic             enable;
    logic [7:0]       rate;
    logic             strobe_in;
    logic             strobe;
    logic             clear_err;
    logic             locked;
    logic             err;
    logic [ERR_W-1:0] err_count;
    logic [8:0]       period;
    logic             err_sticky;

    modport master (
        output enable, rate, strobe_in, strobe, clear_err,
        input  locked, err, err_count, period, err_sticky
    );

    modport slave (
        input  enable, rate, strobe_in, strobe, clear_err,
        output locked, err, err_count, period, err_sticky
    );
endinterface

// File: rtl/strobe_check.sv
// strobe_check: receive-side health monitor for a divided-strobe chain.
// It checks that one strobe arrives every rate+1 qualifier pulses.
// It flags early, late and unqualified strobes.
// It reports lock, an error pulse, a saturating error count and the last
// measured period.
// Optional feature: define STROBE_CHECK_STICKY_EN to build the sticky
// error flag. Without that macro, err_sticky is held at 0.
module strobe_check #(
    parameter int LOCK_COUNT = 4,
    parameter int ERR_W      = 16
) (
    input logic           clock,
    input logic           reset,
    strobe_check_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACQ    = 2'd1;
    localparam logic [1:0] ST_TRACK  = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;

    localparam logic [3:0]       GOOD_MAX = 4'(LOCK_COUNT);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    logic [1:0]       state_reg, state_next;
    logic [7:0]       cnt_reg, cnt_next;
    logic [3:0]       good_reg, good_next;
    logic [7:0]       rate_q_reg, rate_q_next;
    logic             locked_reg, locked_next;
    logic             err_reg;
    logic [ERR_W-1:0] err_count_reg, err_count_next;
    logic [8:0]       period_reg, period_next;
    logic             err_hit;

    // Next-state decision. The enable check comes first, then the rate
    // change check, then the strobe checks. At most one error per cycle.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        good_next   = good_reg;
        rate_q_next = rate_q_reg;
        locked_next = locked_reg;
        period_next = period_reg;
        err_hit     = 1'b0;

        if (!bus.enable) begin
            state_next  = ST_IDLE;
            cnt_next    = 8'd0;
            good_next   = 4'd0;
            locked_next = 1'b0;
        end else if (state_reg == ST_IDLE) begin
            state_next  = ST_ACQ;
            rate_q_next = bus.rate;
        end else if (bus.rate != rate_q_reg) begin
            // A new ratio means the old measurement is meaningless.
            // Restart acquisition silently.
            rate_q_next = bus.rate;
            state_next  = ST_ACQ;
            cnt_next    = 8'd0;
            good_next   = 4'd0;
            locked_next = 1'b0;
        end else if (bus.strobe && !bus.strobe_in) begin
            // Unqualified strobe: report it, but leave the interval untouched.
            err_hit = 1'b1;
        end else if (bus.strobe_in) begin
            if (state_reg == ST_ACQ) begin
                if (bus.strobe) begin
                    state_next = ST_TRACK;
                    cnt_next   = 8'd0;
                    good_next  = 4'd0;
                end
            end else if (!bus.strobe) begin
                if (cnt_reg == rate_q_reg) begin
                    // The expected strobe did not come: late.
                    err_hit    = 1'b1;
                    state_next = ST_ACQ;
                    cnt_next   = 8'd0;
                    good_next  = 4'd0;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end else begin
                period_next = {1'b0, cnt_reg} + 9'd1;
                cnt_next    = 8'd0;
                if (cnt_reg == rate_q_reg) begin
                    if (good_reg >= GOOD_MAX - 4'd1) begin
                        good_next   = GOOD_MAX;
                        state_next  = ST_LOCKED;
                        locked_next = 1'b1;
                    end else begin
                        good_next = good_reg + 4'd1;
                    end
                end else begin
                    // Early strobe: this strobe starts the next interval.
                    err_hit    = 1'b1;
                    good_next  = 4'd0;
                    state_next = ST_TRACK;
                end
            end
        end

        if (err_hit) begin
            locked_next = 1'b0;
        end
    end

    // Error counter: clear first, then count, so clear plus error gives 1.
    always_comb begin
        err_count_next = bus.clear_err ? '0 : err_count_reg;
        if (err_hit && err_count_next != ERR_MAX) begin
            err_count_next = err_count_next + 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 8'd0;
            good_reg      <= 4'd0;
            rate_q_reg    <= 8'd0;
            locked_reg    <= 1'b0;
            err_reg       <= 1'b0;
            err_count_reg <= '0;
            period_reg    <= 9'd0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            good_reg      <= good_next;
            rate_q_reg    <= rate_q_next;
            locked_reg    <= locked_next;
            err_reg       <= err_hit;
            err_count_reg <= err_count_next;
            period_reg    <= period_next;
        end
    end

    assign bus.locked    = locked_reg;
    assign bus.err       = err_reg;
    assign bus.err_count = err_count_reg;
    assign bus.period    = period_reg;

`ifdef STROBE_CHECK_STICKY_EN
    logic sticky_reg;

    // Sticky flag: an error wins over a clear in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sticky_reg <= 1'b0;
        end else if (err_hit) begin
            sticky_reg <= 1'b1;
        end else if (bus.clear_err) begin
            sticky_reg <= 1'b0;
        end
    end

    assign bus.err_sticky = sticky_reg;
`else
    assign bus.err_sticky = 1'b0;
`endif
endmodule

// File: tb/tb_strobe_check.sv
// Self-checking bench for strobe_check.
// Directed scenarios are followed by a randomized stream.
// Every output is compared each cycle against a behavioural model of the
// divide-ratio rules.
module tb_strobe_check;
    localparam int LOCK_COUNT = 4;
    localparam int ERR_W      = 16;
    localparam int ERR_MAX    = (1 << ERR_W) - 1;

    logic clock = 1'b0;
    logic reset = 1'b0;

    strobe_check_if #(.ERR_W(ERR_W)) bus ();

    strobe_check #(.LOCK_COUNT(LOCK_COUNT), .ERR_W(ERR_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: the monitor is idle, acquiring, or measuring the interval.
    bit m_idle = 1'b1;
    bit m_acq  = 1'b0;
    int m_rate = 0;
    int m_since = 0;   // qualifiers seen since the last accepted strobe
    int m_good  = 0;   // run of consecutive correct intervals
    int e_locked = 0, e_err = 0, e_count = 0, e_period = 0, e_sticky = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit error;
        error = 1'b0;
        if (!reset) begin
            m_idle = 1'b1; m_acq = 1'b0; m_rate = 0; m_since = 0; m_good = 0;
            e_locked = 0; e_err = 0; e_count = 0; e_period = 0; e_sticky = 0;
            return;
        end
        if (!bus.enable) begin
            m_idle = 1'b1; m_acq = 1'b0; m_since = 0; m_good = 0; e_locked = 0;
        end else if (m_idle) begin
            m_idle = 1'b0; m_acq = 1'b1; m_rate = int'(bus.rate);
        end else if (int'(bus.rate) != m_rate) begin
            m_rate = int'(bus.rate); m_acq = 1'b1; m_since = 0; m_good = 0; e_locked = 0;
        end else if (bus.strobe && !bus.strobe_in) begin
            error = 1'b1;
        end else if (bus.strobe_in) begin
            if (m_acq) begin
                if (bus.strobe) begin
                    m_acq = 1'b0; m_since = 0; m_good = 0;
                end
            end else if (!bus.strobe) begin
                if (m_since + 1 > m_rate) begin
                    // The interval would exceed rate+1 qualifiers.
                    error = 1'b1; m_acq = 1'b1; m_since = 0; m_good = 0;
                end else begin
                    m_since++;
                end
            end else begin
                e_period = m_since + 1;
                if (e_period == m_rate + 1) begin
                    m_good = (m_good + 1 > LOCK_COUNT) ? LOCK_COUNT : m_good + 1;
                    if (m_good == LOCK_COUNT) e_locked = 1;
                end else begin
                    error = 1'b1; m_good = 0;
                end
                m_since = 0;
            end
        end
        if (bus.clear_err) begin
            e_count = 0;
            e_sticky = 0;
        end
        e_err = error ? 1 : 0;
        if (error) begin
            e_locked = 0;
            if (e_count < ERR_MAX) e_count++;
`ifdef STROBE_CHECK_STICKY_EN
            e_sticky = 1;
`endif
        end
    endtask

    task automatic tick(input logic en, input logic [7:0] r, input logic si,
                        input logic st, input logic ce);
        bus.enable = en; bus.rate = r; bus.strobe_in = si; bus.strobe = st; bus.clear_err = ce;
        model_step();
        @(posedge clock);
        #1;
        check_val("locked",     32'(bus.locked),     32'(e_locked));
        check_val("err",        32'(bus.err),        32'(e_err));
        check_val("err_count",  32'(bus.err_count),  32'(e_count));
        check_val("period",     32'(bus.period),     32'(e_period));
        check_val("err_sticky", 32'(bus.err_sticky), 32'(e_sticky));
    endtask

    // n intervals of gap qualifiers each; the strobe rides the last one.
    task automatic run_gap(input logic [7:0] r, input int gap, input int n);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < gap; k++) begin
                tick(1'b1, r, 1'b1, k == gap - 1, 1'b0);
            end
        end
    endtask

    initial begin
        int gr, gcnt;
        logic si, st;
        bus.enable = 1'b0; bus.rate = 8'd0; bus.strobe_in = 1'b0;
        bus.strobe = 1'b0; bus.clear_err = 1'b0;

        // Reset with busy inputs: everything must read 0.
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b1, 8'(i), 1'b1, 1'b1, 1'b0);
        reset = 1'b1;

        // Nominal stream at rate 3, then lock.
        tick(1'b1, 8'd3, 1'b1, 1'b0, 1'b0);
        run_gap(8'd3, 4, 6);
        check_val("lock_nominal", 32'(bus.locked), 32'd1);

        // Early strobe, then relock.
        run_gap(8'd3, 3, 1);
        check_val("early_period", 32'(bus.period), 32'd3);
        run_gap(8'd3, 4, 5);

        // Omitted strobe (late), then reacquire and relock.
        run_gap(8'd3, 8, 1);
        run_gap(8'd3, 4, 5);

        // Unqualified strobe while locked.
        tick(1'b1, 8'd3, 1'b0, 1'b1, 1'b0);
        run_gap(8'd3, 4, 3);

        // Ratio change 3 -> 7 mid-stream.
        run_gap(8'd7, 8, 6);
        check_val("rate7_period", 32'(bus.period), 32'd8);
        check_val("rate7_lock",   32'(bus.locked), 32'd1);

        // One cycle of reset clears all outputs.
        reset = 1'b0;
        tick(1'b1, 8'd7, 1'b1, 1'b1, 1'b0);
        reset = 1'b1;

        // rate 0: every qualifier must carry a strobe.
        tick(1'b1, 8'd0, 1'b1, 1'b0, 1'b0);
        run_gap(8'd0, 1, 6);
        tick(1'b1, 8'd0, 1'b1, 1'b0, 1'b0);

        // Saturate the error counter with unqualified strobes.
        for (int i = 0; i < ERR_MAX + 3; i++) tick(1'b1, 8'd0, 1'b0, 1'b1, 1'b0);
        check_val("sat_count", 32'(bus.err_count), 32'(ERR_MAX));
        tick(1'b1, 8'd0, 1'b0, 1'b1, 1'b1);
        check_val("clear_with_err", 32'(bus.err_count), 32'd1);
        tick(1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);

        // Randomized stream with mostly-correct strobes and occasional noise.
        gr = 2; gcnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                gr = $urandom_range(0, 5);
                gcnt = 0;
            end
            si = ($urandom_range(0, 3) != 0);
            st = si && (gcnt == gr);
            if (si) gcnt = (gcnt == gr) ? 0 : gcnt + 1;
            if ($urandom_range(0, 29) == 0) st = ~st;
            tick($urandom_range(0, 399) != 0, 8'(gr), si, st, $urandom_range(0, 99) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/strobe_check.md
Name: strobe_check

Overview:
- Receiving-end monitor for the divided-strobe protocol: watches a qualifier stream `strobe_in` and a divided stream `strobe` (one `strobe` per rate+1 qualifier pulses).
- Verifies the divide ratio, detects early, late and unqualified strobes, and reports lock, error pulses, error count and last measured period.
- Sits beside decimator/interpolator strobe chains as a debug/health block whose outputs are readable through the status registers.

Parameters:
- LOCK_COUNT, 4: consecutive good periods needed to assert `locked` (1..15).
- ERR_W, 16: width of the saturating error counter.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on posedge clock.
- enable  input  1  0 forces IDLE, clears the interval counter and deasserts `locked`.
- rate  input  8  expected divide ratio minus 1 (same encoding as the generator).
- strobe_in  input  1  qualifier strobe.
- strobe  input  1  divided strobe under test.
- clear_err  input  1  synchronous clear of `err_count` (and `err_sticky`).
- locked  output  1  ratio verified for LOCK_COUNT consecutive periods.
- err  output  1  one-cycle error pulse.
- err_count  output  ERR_W  saturating count of errors.
- period  output  9  last measured interval in qualifier pulses (cnt+1).
- err_sticky  output  1  see Optional Feature.

Behaviour:
- Reset (reset==0), all outputs: locked=0, err=0, err_count=0, period=0, err_sticky=0; state=IDLE; cnt=0, good=0, rate_q=0.
- All outputs are registered; responses appear 1 cycle after the causing input cycle.
- States and transitions:
  - IDLE: leave to ACQ when enable==1; rate_q<=rate.
  - ACQ: wait for the first strobe. strobe&&strobe_in -> cnt<=0, TRACK, good<=0. No checks in ACQ other than unqualified strobe.
  - TRACK/LOCKED, on a strobe_in cycle:
    - strobe==0, cnt<rate_q -> cnt<=cnt+1.
    - strobe==0, cnt==rate_q -> LATE error; go ACQ, cnt<=0.
    - strobe==1, cnt==rate_q -> good period; period<=cnt+1; cnt<=0; good<=good+1 (saturate at LOCK_COUNT); go LOCKED when good reaches LOCK_COUNT.
    - strobe==1, cnt<rate_q -> EARLY error; period<=cnt+1; cnt<=0; good<=0; go TRACK (this strobe restarts the interval).
- Unqualified strobe (strobe==1 && strobe_in==0): error in any non-IDLE state; state, cnt and good unchanged.
- Cycles with strobe_in==0 && strobe==0 change nothing.
- rate!=rate_q while not IDLE: silent restart (no error). rate_q<=rate, go ACQ, cnt<=0, good<=0, locked<=0. This check has priority over the strobe checks in the same cycle.
- Error handling:
  - Any error -> err=1 for exactly 1 cycle, err_count+=1 saturating at all-ones, locked<=0.
  - At most one error per cycle.
- clear_err: err_count<=0. If an error occurs in the same cycle, the result is 1 (clear then count).
- enable==0 from any state -> IDLE next cycle, locked<=0, cnt<=0. err_count and period are retained.
- rate==0: every qualified strobe_in must carry strobe. Any qualifier without strobe in TRACK/LOCKED is LATE.
- cnt is 8-bit and never exceeds rate_q, so it cannot wrap.
- reset has priority over enable, clear_err and all other inputs.

Optional Feature:
- Macro: STROBE_CHECK_STICKY_EN.
- Defined: err_sticky sets on any error and holds until clear_err==1 or reset. An error in the same cycle as clear_err leaves it at 1.
- Undefined: err_sticky is tied to 0 and no sticky register is built. The port remains present.

Test Plan:
- rate=3, strobe_in every cycle, strobe every 4th cycle -> period=4 after each strobe; locked=1 one cycle after the 5th strobe (ACQ strobe + 4 good); err never asserts.
- Locked at rate=3, then a strobe arrives after 2 qualifiers -> err pulse 1 cycle, err_count=1, period=3, locked=0; relocks after 4 further good periods.
- Locked at rate=3, then a strobe is omitted -> err on the 4th qualifier after the last strobe, state ACQ, err_count increments by 1; the next strobe re-acquires.
- Pulse strobe with strobe_in=0 while locked -> err=1, err_count+1, locked=0; cnt is unaffected, so following correct strobes are good periods.
- Change rate 3->7 mid-stream -> no err, locked=0; with strobes every 8 qualifiers, locked returns after 5 strobes, period=8. Then hold reset low 1 cycle -> all outputs 0.
- err_count at 16'hFFFF plus another error -> stays FFFF. Assert clear_err with a simultaneous error -> err_count=1. With STROBE_CHECK_STICKY_EN: err_sticky=1 until clear_err; without it, err_sticky stays 0.
